// File: rtl/arb_requester.sv
// arb_requester: four independent channels that queue jobs and drive a burst-per-job request/grant handshake
module arb_requester #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned PEND_W    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic push0,
    input  logic push1,
    input  logic push2,
    input  logic push3,
    input  logic gnt0,
    input  logic gnt1,
    input  logic gnt2,
    input  logic gnt3,
    output logic req0,
    output logic req1,
    output logic req2,
    output logic req3,
    output logic done0,
    output logic done1,
    output logic done2,
    output logic done3,
    output logic busy0,
    output logic busy1,
    output logic busy2,
    output logic busy3,
    output logic ovf0,
    output logic ovf1,
    output logic ovf2,
    output logic ovf3,
    output logic perr0,
    output logic perr1,
    output logic perr2,
    output logic perr3
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;
    state_t            st_q   [4];
    state_t            st_d   [4];
    logic [PEND_W-1:0] pend_q [4];
    logic [PEND_W-1:0] pend_d [4];
    logic [3:0]        beat_q [4];
    logic [3:0]        beat_d [4];
    logic [3:0]        done_q, done_d, ovf_q, ovf_d, perr_q, perr_d;
    logic [3:0]        push, gnt, req, busy, hit, cmpl;
    assign push = {push3, push2, push1, push0};
    assign gnt  = {gnt3, gnt2, gnt1, gnt0};
    assign {req3, req2, req1, req0}     = req;
    assign {busy3, busy2, busy1, busy0} = busy;
    assign {done3, done2, done1, done0} = done_q;
    assign {ovf3, ovf2, ovf1, ovf0}     = ovf_q;
    assign {perr3, perr2, perr1, perr0} = perr_q;
    always_comb begin
        req    = '0;
        busy   = '0;
        hit    = '0;
        cmpl   = '0;
        done_d = '0;
        ovf_d  = ovf_q;
        perr_d = perr_q;
        st_d   = st_q;
        pend_d = pend_q;
        beat_d = beat_q;
        for (int i = 0; i < 4; i++) begin
            req[i]    = st_q[i] == REQ || st_q[i] == XFER;
            busy[i]   = pend_q[i] != '0 || st_q[i] != IDLE;
            hit[i]    = req[i] && gnt[i];
            // beat_q is 0 in REQ, so a single-beat burst completes on its first beat
            cmpl[i]   = hit[i] && beat_q[i] == 4'(BURST_LEN - 1);
            beat_d[i] = hit[i] ? (cmpl[i] ? 4'd0 : beat_q[i] + 4'd1) : beat_q[i];
            st_d[i]   = !req[i] ? (pend_q[i] != '0 ? REQ : IDLE) : cmpl[i] ? REL : hit[i] ? XFER : st_q[i];
            pend_d[i] = push[i] && !cmpl[i] && pend_q[i] != '1 ? pend_q[i] + PEND_W'(1)
                      : !push[i] && cmpl[i] ? pend_q[i] - PEND_W'(1) : pend_q[i];
            ovf_d[i]  = ovf_q[i] || (push[i] && !cmpl[i] && pend_q[i] == '1);
            perr_d[i] = perr_q[i] || (gnt[i] && !req[i]);
            done_d[i] = cmpl[i];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= '{default: IDLE};
            pend_q <= '{default: '0};
            beat_q <= '{default: '0};
            done_q <= '0;
            ovf_q  <= '0;
            perr_q <= '0;
        end else begin
            st_q   <= st_d;
            pend_q <= pend_d;
            beat_q <= beat_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
            perr_q <= perr_d;
        end
    end
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed bench for arb_requester driven by a registered round-robin burst arbiter model
module tb_arb_requester;
    localparam int BL = 4;
    logic       clk, rst, man, mclr;
    logic [3:0] push, man_g, arb_g, mask;
    wire  [3:0] gnt, req, done, busy, ovf, perr, arb_req;
    int         arb_cnt, arb_last;
    int         n_chk, n_err;
    int         done_n [4], beat_n [4], rise_n [4], low_n [4], run [4], bad_n [4];
    int         gnt_tot, ovl;
    logic [3:0] req_prev;

    assign gnt     = man ? man_g : arb_g;
    assign arb_req = req & ~mask;

    arb_requester #(.BURST_LEN(BL), .PEND_W(3)) dut (
        .clk(clk), .rst(rst),
        .push0(push[0]), .push1(push[1]), .push2(push[2]), .push3(push[3]),
        .gnt0(gnt[0]), .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]),
        .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
        .done0(done[0]), .done1(done[1]), .done2(done[2]), .done3(done[3]),
        .busy0(busy[0]), .busy1(busy[1]), .busy2(busy[2]), .busy3(busy[3]),
        .ovf0(ovf[0]), .ovf1(ovf[1]), .ovf2(ovf[2]), .ovf3(ovf[3]),
        .perr0(perr[0]), .perr1(perr[1]), .perr2(perr[2]), .perr3(perr[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // arbiter model: registered grant, exactly BL cycles per holder, round-robin hand-over
    always @(posedge clk) begin : arb
        logic [3:0] nx;
        int         nl;
        nx = '0;
        nl = arb_last;
        for (int k = 1; k <= 4; k++)
            if (nx == 0 && arb_req[(arb_last + k) % 4] && !arb_g[(arb_last + k) % 4]) begin
                nx[(arb_last + k) % 4] = 1'b1;
                nl = (arb_last + k) % 4;
            end
        if (rst) begin
            arb_g    <= '0;
            arb_cnt  <= 0;
            arb_last <= 3;
        end else if (arb_g != 0 && arb_cnt != BL - 1) begin
            arb_cnt <= arb_cnt + 1;
        end else begin
            arb_g    <= nx;
            arb_cnt  <= 0;
            arb_last <= nl;
        end
    end

    always @(negedge clk) begin
        if (mclr) begin
            for (int i = 0; i < 4; i++) begin
                done_n[i] <= 0; beat_n[i] <= 0; rise_n[i] <= 0;
                low_n[i]  <= 0; run[i]    <= 0; bad_n[i]  <= 0;
            end
            gnt_tot  <= 0;
            ovl      <= 0;
            req_prev <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                done_n[i] <= done_n[i] + int'(done[i]);
                beat_n[i] <= beat_n[i] + int'(req[i] & gnt[i]);
                rise_n[i] <= rise_n[i] + int'(req[i] & ~req_prev[i]);
                low_n[i]  <= low_n[i] + int'(busy[i] & ~req[i]);
                if (req[i] && gnt[i]) run[i] <= run[i] + 1;
                else if (run[i] != 0) begin
                    run[i] <= 0;
                    if (run[i] != BL) bad_n[i] <= bad_n[i] + 1;
                end
            end
            gnt_tot  <= gnt_tot + int'(|gnt);
            ovl      <= ovl + int'($countones(gnt) > 1);
            req_prev <= req;
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst  = 1'b1;
        mclr = 1'b1;
        push = '0;
        tick(2);
        rst  = 1'b0;
        mclr = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int c = 0;
        while (busy != 0 && c < max) begin
            tick(1);
            c++;
        end
        check(tag, int'(busy), 0);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        man = 1'b0; man_g = '0; mask = '0; push = '0;
        do_rst();
        check("rst_outputs", int'({req, done, busy, ovf, perr}), 0);

        // single job
        push = 4'b0001; tick(1); push = '0;
        check("s1_req_early", int'(req[0]), 0);
        check("s1_busy", int'(busy[0]), 1);
        tick(1);
        check("s1_req", int'(req[0]), 1);
        tick(1);
        check("s1_gnt", int'(gnt[0]), 1);
        tick(4);
        check("s1_done", int'(done[0]), 1);
        check("s1_req_fall", int'(req[0]), 0);
        tick(1);
        check("s1_done_pulse", int'(done[0]), 0);
        check("s1_busy_end", int'(busy[0]), 0);
        check("s1_done_cnt", done_n[0], 1);
        check("s1_beats", beat_n[0], 4);
        check("s1_perr", int'(perr), 0);

        // back-to-back jobs on channel 1
        do_rst();
        push = 4'b0010; tick(3); push = '0;
        wait_idle("b2b_idle", 200);
        check("b2b_done", done_n[1], 3);
        check("b2b_beats", beat_n[1], 12);
        check("b2b_bursts", rise_n[1], 3);
        check("b2b_low_cycles", low_n[1], 4);
        check("b2b_bad_runs", bad_n[1], 0);
        check("b2b_perr", int'(perr), 0);

        // contention
        do_rst();
        push = 4'b1111; tick(1); push = '0;
        wait_idle("ct_idle", 200);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ct_done%0d", i), done_n[i], 1);
            check($sformatf("ct_beats%0d", i), beat_n[i], 4);
            check($sformatf("ct_runs%0d", i), bad_n[i], 0);
        end
        check("ct_overlap", ovl, 0);
        check("ct_gnt_total", gnt_tot, 16);
        check("ct_perr", int'(perr), 0);

        // push coinciding with completion
        do_rst();
        push = 4'b0001; tick(1); push = '0;
        tick(5);
        push = 4'b0001; tick(1); push = '0;
        check("pc_done", int'(done[0]), 1);
        check("pc_req_rel", int'(req[0]), 0);
        tick(1);
        check("pc_req_again", int'(req[0]), 1);
        wait_idle("pc_idle", 200);
        check("pc_done_cnt", done_n[0], 2);
        check("pc_beats", beat_n[0], 8);

        // grant gap mid-burst
        man = 1'b1; man_g = '0;
        do_rst();
        push = 4'b0001; tick(1); push = '0;
        tick(1);
        man_g = 4'b0001; tick(2);
        man_g = '0; tick(3);
        check("gap_req_held", int'(req[0]), 1);
        check("gap_no_done", done_n[0], 0);
        man_g = 4'b0001; tick(1);
        check("gap_beat3", int'({req[0], done[0]}), 2);
        tick(1);
        man_g = '0;
        check("gap_done", int'({req[0], done[0]}), 1);
        check("gap_beats", beat_n[0], 4);
        check("gap_perr", int'(perr), 0);
        man = 1'b0;

        // saturation on channel 2 while it is starved
        do_rst();
        mask = 4'b0100;
        for (int k = 0; k < 9; k++) begin
            push = k < 3 ? 4'b1100 : 4'b0100;
            tick(1);
            if (k == 6) check("sat_ovf_pre", int'(ovf[2]), 0);
            if (k == 7) check("sat_ovf_set", int'(ovf[2]), 1);
        end
        push = '0;
        check("sat_starved", done_n[2], 0);
        check("sat_busy", int'(busy[2]), 1);
        mask = '0;
        wait_idle("sat_idle", 2000);
        check("sat_done2", done_n[2], 7);
        check("sat_done3", done_n[3], 3);
        check("sat_ovf_sticky", int'(ovf), 4);
        check("sat_perr", int'(perr), 0);

        // mid-burst reset, also racing pushes
        do_rst();
        push = 4'b0011; tick(1);
        push = 4'b0001; tick(1); push = '0;
        tick(1);
        check("mr_gnt", int'(gnt), 1);
        tick(2);
        rst = 1'b1; push = 4'b1111; tick(1);
        rst = 1'b0; push = '0;
        check("mr_req", int'(req), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_done", int'(done), 0);
        tick(8);
        check("mr_quiet", int'({req, busy}), 0);
        check("mr_no_done", done_n[0] + done_n[1], 0);

        // grant while not requesting
        man = 1'b1; man_g = '0;
        do_rst();
        man_g = 4'b0100; tick(1); man_g = '0;
        check("pe_perr", int'(perr), 4);
        check("pe_no_fsm", int'({req[2], busy[2]}), 0);
        tick(3);
        check("pe_sticky", int'(perr), 4);
        man = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/arb_requester.md
# arb_requester

Four-channel request agent that drives the `req3..req0` / `gnt3..gnt0` handshake of the round-robin `arbiter` from the requester side. Each channel queues locally posted jobs and raises its request while jobs are pending. It holds the request for exactly `BURST_LEN` granted beats, then releases for one cycle so the arbiter can rotate. It sits between the job-producing logic and the arbiter, and is the bench/driver counterpart used to exercise and integrate the arbiter.

## Interface
- `BURST_LEN`, default 4: granted beats per job. Legal range 1..15.
- `PEND_W`, default 3: width of each channel's pending-job counter. Saturates at 2^PEND_W-1 (default 7).
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `push3..push0` input, 1 bit each: a one-cycle pulse posts one job to channel i.
- `gnt3..gnt0` input, 1 bit each: grant from the arbiter, one-hot or zero.
- `req3..req0` output, 1 bit each: registered request to the arbiter.
- `done3..done0` output, 1 bit each: one-cycle pulse when channel i completes a job.
- `busy3..busy0` output, 1 bit each: channel i has pending jobs or is mid-job.
- `ovf3..ovf0` output, 1 bit each: sticky flag. A push was dropped because the counter was saturated.
- `perr3..perr0` output, 1 bit each: sticky flag. `gnt_i` was sampled high while `req_i` was low.

## Operation
- There are four identical, independent channel instances. There is no interaction between channels.
- Per-channel state:
  - pending counter `pend` (PEND_W bits)
  - beat counter `beat` (4 bits)
  - FSM with states IDLE, REQ, XFER, REL
- A beat is any rising edge where `req_i`=1 and `gnt_i`=1.
- FSM transitions:
  - IDLE: `req_i`=0. Go to REQ when `pend`>0.
  - REQ: `req_i`=1, `beat`=0. On a beat, go to XFER with `beat`=1. If `BURST_LEN`=1, that beat completes the job and the FSM goes to REL instead.
  - XFER: `req_i`=1. Each beat increments `beat`. The beat that brings `beat` to `BURST_LEN` completes the job: go to REL, pulse `done_i`, decrement `pend`.
  - XFER with `gnt_i` low: hold `req_i` and `beat` unchanged. Resume counting when the grant returns. The job is never restarted.
  - REL: `req_i`=0 for exactly one cycle. Then go to REQ if `pend`>0, else IDLE.
- `pend` arithmetic:
  - +1 on push, −1 on completion, unchanged on both together.
  - Push at saturation with no completion: the push is dropped and `ovf_i` is set.
  - It never wraps.
  - A completion always has `pend`≥1, since the in-flight job is counted in `pend`.
- `busy_i` = (`pend`≠0) or (state≠IDLE).
- `perr_i` is set on any edge with `gnt_i`=1 and `req_i`=0. Its state is otherwise ignored, and the FSM does not change because of it.
- Reset: all FSMs go to IDLE; `pend`, `beat`, every `req`, `done`, `busy`, `ovf` and `perr` are 0. Reset mid-job abandons the job; no `done` is issued.

## Timing
- Push sampled at edge n: `pend` updates at n+1 and `req_i`=1 from n+2 (IDLE→REQ is one registered step).
- The arbiter registers grants, so the first beat is at the earliest edge n+3.
- `req_i` is high for exactly `BURST_LEN` beats plus any grant-gap cycles.
- `done_i` and the fall of `req_i` occur in the cycle after the final beat edge.
- Back-to-back jobs on one channel: `req_i` is low for exactly one cycle (REL) between them.
- A push in the same cycle as `done_i` is counted, and the net effect on `pend` is 0.
- `rst` has priority over push, gnt and all transitions in the same cycle.

## Test plan
Every scenario runs with the DUT connected to `arbiter`, `BURST_LEN`=4.

- **Single job:** reset, then `push0` at cycle 2 → `req0` high from cycle 4, `gnt0` for 4 beats, `done0` one pulse, `req0` low, `busy0`=0, `perr`=0.
- **Back-to-back jobs:** `push1` ×3 on consecutive cycles → `pend1` reaches 3; three bursts of 4 beats, each separated by exactly one `req1`-low cycle; 3 `done1` pulses; `busy1` falls after the third.
- **Contention:** `push0..push3` in the same cycle → each channel gets exactly 4 consecutive granted beats, grants never overlap, all four `done` pulses occur, total grant cycles = 16.
- **Saturation:** 9 pushes to channel 2 while it is starved by a long channel-3 workload → `pend2`=7, `ovf2`=1 and it stays 1. Exactly 7 `done2` pulses follow.
- **Push with completion:** `push0` in the same cycle as `done0` with `pend0`=1 → `pend0` stays 1 and a new burst starts after REL.
- **Mid-burst reset and error injection:**
  - `rst` after 2 beats → next cycle all `req`=0, `pend`=0, no `done`.
  - A forced `gnt2` while `req2`=0 → `perr2`=1, with no FSM change.
